lsu_axi_gpio_slave: RTL and testbench

AXI4 write/read slave that terminates the BrqRV EB1 LSU AXI port inside the user project and owns the user-area GPIO output and output-enable registers. It sits directly downstream of the core's LSU AXI master. It replaces the open-loop strobe-to-pad wiring with a proper handshake: the core sees real `awready`, `wready` and `bvalid` responses, and the core can read back register state over R.

---
 rtl/lsu_gpio_pkg.sv | 27 ++
 rtl/lsu_axi_gpio_slave.sv | 175 +++++++++++++++++
 tb/tb_lsu_axi_gpio_slave.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_gpio_pkg.sv
// Shared definitions for the LSU AXI GPIO slave.
// Holds the register offsets, AXI response codes, the write/read FSM state
// types and the byte-lane merge helper used when a write commits.
package lsu_gpio_pkg;

    localparam logic [3:0] OFF_OUT     = 4'h0;
    localparam logic [3:0] OFF_OEB     = 4'h4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    // Bytes whose strobe bit is set take the new data; the rest keep old.
    function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb4);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (strb4[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_axi_gpio_slave.sv
// AXI4 slave terminating the core LSU AXI port and owning the GPIO_OUT and
// GPIO_OEB registers. One write and one read may be in flight at a time,
// independently of each other; every burst is treated as a single beat.
//
// Ports:
//   wb_clk_i, wb_rst_i        clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*           AXI write address, write data, write response
//   s_ar*/s_r*                AXI read address, read data
//   gpio_out                  GPIO_OUT register (offset 0x0, lane 0)
//   gpio_oeb                  GPIO_OEB register (offset 0x4, lane 1), 1 = input
module lsu_axi_gpio_slave
    import lsu_gpio_pkg::*;
#(
    parameter int                  ID_W      = 3,
    parameter int                  ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = 32'h8000_1000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [ID_W-1:0]   s_awid,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_wvalid,
    output logic              s_wready,
    input  logic [63:0]       s_wdata,
    input  logic [7:0]        s_wstrb,
    output logic              s_bvalid,
    input  logic              s_bready,
    output logic [ID_W-1:0]   s_bid,
    output logic [1:0]        s_bresp,
    input  logic              s_arvalid,
    output logic              s_arready,
    input  logic [ID_W-1:0]   s_arid,
    input  logic [ADDR_W-1:0] s_araddr,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [ID_W-1:0]   s_rid,
    output logic [63:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rlast,
    output logic [31:0]       gpio_out,
    output logic [31:0]       gpio_oeb
);

    wr_state_t         wr_state, wr_state_nxt;
    rd_state_t         rd_state, rd_state_nxt;

    logic              aw_held, w_held;
    logic [ID_W-1:0]   awid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [63:0]       wdata_q;
    logic [7:0]        wstrb_q;

    // OKAY only for the two registers inside the 16-byte window; addr[1:0]
    // is don't-care.
    function automatic logic [1:0] decode_resp(input logic [ADDR_W-1:0] a);
        logic [3:0] off;
        off = {a[3:2], 2'b00};
        if ((a[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]) &&
            ((off == OFF_OUT) || (off == OFF_OEB)))
            return RESP_OKAY;
        return RESP_SLVERR;
    endfunction

    // Readies are plain decodes of state so the handshake terms below have
    // no path back through the next-state logic.
    assign s_awready = (wr_state == W_IDLE) && !aw_held;
    assign s_wready  = (wr_state == W_IDLE) && !w_held;
    assign s_bvalid  = (wr_state == W_RESP);
    assign s_arready = (rd_state == R_IDLE);
    assign s_rvalid  = (rd_state == R_DATA);
    assign s_rlast   = s_rvalid;

    logic              aw_fire, w_fire, ar_fire, wr_commit;
    logic [ADDR_W-1:0] cur_awaddr;
    logic [ID_W-1:0]   cur_awid;
    logic [63:0]       cur_wdata;
    logic [7:0]        cur_wstrb;
    logic [1:0]        cur_wresp;
    logic              cur_sel_oeb;

    assign aw_fire   = s_awvalid && s_awready;
    assign w_fire    = s_wvalid && s_wready;
    assign ar_fire   = s_arvalid && s_arready;

    // A channel caught in an earlier cycle comes from its holding register,
    // otherwise straight from the bus, so the commit can happen on the same
    // edge as the later of the two handshakes.
    assign cur_awaddr  = aw_held ? awaddr_q : s_awaddr;
    assign cur_awid    = aw_held ? awid_q   : s_awid;
    assign cur_wdata   = w_held  ? wdata_q  : s_wdata;
    assign cur_wstrb   = w_held  ? wstrb_q  : s_wstrb;
    assign cur_wresp   = decode_resp(cur_awaddr);
    assign cur_sel_oeb = ({cur_awaddr[3:2], 2'b00} == OFF_OEB);
    assign wr_commit   = (wr_state == W_IDLE) &&
                         (aw_held || aw_fire) && (w_held || w_fire);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_state <= W_IDLE;
            rd_state <= R_IDLE;
        end else begin
            wr_state <= wr_state_nxt;
            rd_state <= rd_state_nxt;
        end
    end

    always_comb begin
        wr_state_nxt = wr_state;
        rd_state_nxt = rd_state;
        case (wr_state)
            W_IDLE:  if (wr_commit) wr_state_nxt = W_RESP;
            W_RESP:  if (s_bready)  wr_state_nxt = W_IDLE;
            default: wr_state_nxt = W_IDLE;
        endcase
        case (rd_state)
            R_IDLE:  if (ar_fire)  rd_state_nxt = R_DATA;
            R_DATA:  if (s_rready) rd_state_nxt = R_IDLE;
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    // Write path: channel capture, register merge and B response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            s_bid    <= '0;
            s_bresp  <= RESP_OKAY;
            gpio_out <= 32'h0000_0000;
            gpio_oeb <= 32'hFFFF_FFFF;
        end else if (wr_commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            s_bid   <= cur_awid;
            s_bresp <= cur_wresp;
            if (cur_wresp == RESP_OKAY) begin
                if (cur_sel_oeb)
                    gpio_oeb <= strb_merge(gpio_oeb, cur_wdata[63:32], cur_wstrb[7:4]);
                else
                    gpio_out <= strb_merge(gpio_out, cur_wdata[31:0], cur_wstrb[3:0]);
            end
        end else begin
            if (aw_fire) aw_held <= 1'b1;
            if (w_fire)  w_held  <= 1'b1;
        end
    end

    // Holding registers carry data only; their validity lives in *_held.
    always_ff @(posedge wb_clk_i) begin
        if (aw_fire) begin
            awid_q   <= s_awid;
            awaddr_q <= s_awaddr;
        end
        if (w_fire) begin
            wdata_q <= s_wdata;
            wstrb_q <= s_wstrb;
        end
    end

    // Read path: registers are sampled before any same-edge write lands.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            s_rid   <= '0;
            s_rdata <= '0;
            s_rresp <= RESP_OKAY;
        end else if (ar_fire) begin
            s_rid   <= s_arid;
            s_rresp <= decode_resp(s_araddr);
            s_rdata <= (decode_resp(s_araddr) == RESP_OKAY) ? {gpio_oeb, gpio_out} : 64'd0;
        end
    end

endmodule

// File: tb/tb_lsu_axi_gpio_slave.sv
module tb_lsu_axi_gpio_slave;

    localparam int          ID_W   = 3;
    localparam int          ADDR_W = 32;
    localparam logic [31:0] BASE   = 32'h8000_1000;

    logic              clk;
    logic              rst;
    logic              s_awvalid, s_awready;
    logic [ID_W-1:0]   s_awid;
    logic [ADDR_W-1:0] s_awaddr;
    logic              s_wvalid, s_wready;
    logic [63:0]       s_wdata;
    logic [7:0]        s_wstrb;
    logic              s_bvalid, s_bready;
    logic [ID_W-1:0]   s_bid;
    logic [1:0]        s_bresp;
    logic              s_arvalid, s_arready;
    logic [ID_W-1:0]   s_arid;
    logic [ADDR_W-1:0] s_araddr;
    logic              s_rvalid, s_rready;
    logic [ID_W-1:0]   s_rid;
    logic [63:0]       s_rdata;
    logic [1:0]        s_rresp;
    logic              s_rlast;
    logic [31:0]       gpio_out, gpio_oeb;

    lsu_axi_gpio_slave #(.ID_W(ID_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rresp(s_rresp), .s_rlast(s_rlast),
        .gpio_out(gpio_out), .gpio_oeb(gpio_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference register contents.
    logic [31:0] m_out, m_oeb;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Only the two words at BASE..BASE+7 are registers.
    function automatic logic [1:0] m_resp(input logic [31:0] a);
        if (a >= BASE && a <= BASE + 32'd7) return 2'b00;
        return 2'b10;
    endfunction

    task automatic m_apply(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s);
        int idx;
        if (m_resp(a) != 2'b00) return;
        idx = int'((a - BASE) / 4);
        for (int b = 0; b < 4; b++) begin
            if (s[idx*4 + b]) begin
                if (idx == 0) m_out[b*8 +: 8] = d[b*8 +: 8];
                else          m_oeb[b*8 +: 8] = d[32 + b*8 +: 8];
            end
        end
    endtask

    task automatic m_reset();
        m_out = 32'h0;
        m_oeb = 32'hFFFF_FFFF;
    endtask

    // lead > 0: W arrives lead cycles before AW; lead < 0: AW first; 0: together.
    task automatic do_write(input logic [31:0] a, input logic [ID_W-1:0] id,
                            input logic [63:0] d, input logic [7:0] s,
                            input int lead, input int stall);
        int n;
        logic [1:0] er;
        er = m_resp(a);
        n  = (lead < 0) ? -lead : lead;
        s_bready = (stall == 0);
        @(posedge clk); #1;
        if (lead >= 0) begin s_wvalid = 1'b1; s_wdata = d; s_wstrb = s; end
        if (lead <= 0) begin s_awvalid = 1'b1; s_awaddr = a; s_awid = id; end
        @(posedge clk); #1;
        s_wvalid  = 1'b0;
        s_awvalid = 1'b0;
        if (n != 0) begin
            @(negedge clk);
            chk("b_early", s_bvalid, 1'b0);
            chk("held_ready", (lead > 0) ? s_wready : s_awready, 1'b0);
            chk("other_ready", (lead > 0) ? s_awready : s_wready, 1'b1);
            repeat (n - 1) @(posedge clk);
            #1;
            if (lead > 0) begin s_awvalid = 1'b1; s_awaddr = a; s_awid = id; end
            else          begin s_wvalid = 1'b1; s_wdata = d; s_wstrb = s; end
            @(posedge clk); #1;
            s_wvalid  = 1'b0;
            s_awvalid = 1'b0;
        end
        m_apply(a, d, s);
        @(negedge clk);
        chk("bvalid", s_bvalid, 1'b1);
        chk("bid", s_bid, id);
        chk("bresp", s_bresp, er);
        chk("gpio_out", gpio_out, m_out);
        chk("gpio_oeb", gpio_oeb, m_oeb);
        chk("awready_resp", s_awready, 1'b0);
        chk("wready_resp", s_wready, 1'b0);
        for (int k = 0; k < stall; k++) begin
            @(posedge clk); #1;
            s_awvalid = 1'b1;
            s_awaddr  = BASE + 32'd4;
            s_awid    = id + 1'b1;
            @(negedge clk);
            chk("stall_bvalid", s_bvalid, 1'b1);
            chk("stall_bid", s_bid, id);
            chk("stall_bresp", s_bresp, er);
            chk("stall_awready", s_awready, 1'b0);
            chk("stall_wready", s_wready, 1'b0);
        end
        s_awvalid = 1'b0;
        s_bready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bvalid_done", s_bvalid, 1'b0);
        chk("awready_back", s_awready, 1'b1);
        chk("wready_back", s_wready, 1'b1);
        chk("gpio_out_after", gpio_out, m_out);
        chk("gpio_oeb_after", gpio_oeb, m_oeb);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [ID_W-1:0] id,
                           input int rstall, input bit rst_mid);
        logic [63:0] ed;
        logic [1:0]  er;
        er = m_resp(a);
        ed = (er == 2'b00) ? {m_oeb, m_out} : 64'd0;
        @(posedge clk); #1;
        s_arvalid = 1'b1;
        s_araddr  = a;
        s_arid    = id;
        s_rready  = (rstall == 0 && !rst_mid);
        @(negedge clk);
        chk("arready", s_arready, 1'b1);
        chk("rvalid_early", s_rvalid, 1'b0);
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        @(negedge clk);
        chk("rvalid", s_rvalid, 1'b1);
        chk("rdata", s_rdata, ed);
        chk("rresp", s_rresp, er);
        chk("rlast", s_rlast, 1'b1);
        chk("rid", s_rid, id);
        for (int k = 0; k < rstall; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("rstall_rvalid", s_rvalid, 1'b1);
            chk("rstall_rdata", s_rdata, ed);
            chk("rstall_rid", s_rid, id);
        end
        if (rst_mid) begin
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            m_reset();
            chk("rst_rvalid", s_rvalid, 1'b0);
            chk("rst_rdata", s_rdata, 64'd0);
            chk("rst_gpio_out", gpio_out, m_out);
            chk("rst_gpio_oeb", gpio_oeb, m_oeb);
            s_rready = 1'b1;
        end else begin
            s_rready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk("rvalid_done", s_rvalid, 1'b0);
            chk("arready_back", s_arready, 1'b1);
        end
    endtask

    // Write and read handshake on the same edge: read sees pre-update values.
    task automatic write_read(input logic [31:0] wa, input logic [63:0] d,
                              input logic [7:0] s, input logic [31:0] ra);
        logic [63:0] ed;
        s_bready = 1'b1;
        s_rready = 1'b1;
        ed = (m_resp(ra) == 2'b00) ? {m_oeb, m_out} : 64'd0;
        @(posedge clk); #1;
        s_awvalid = 1'b1; s_awaddr = wa; s_awid = 3'd7;
        s_wvalid  = 1'b1; s_wdata  = d;  s_wstrb = s;
        s_arvalid = 1'b1; s_araddr = ra; s_arid = 3'd2;
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        m_apply(wa, d, s);
        @(negedge clk);
        chk("wr_bvalid", s_bvalid, 1'b1);
        chk("wr_bresp", s_bresp, m_resp(wa));
        chk("wr_rvalid", s_rvalid, 1'b1);
        chk("wr_rdata_pre", s_rdata, ed);
        chk("wr_gpio_out", gpio_out, m_out);
        chk("wr_gpio_oeb", gpio_oeb, m_oeb);
        @(posedge clk);
        @(negedge clk);
        chk("wr_bdone", s_bvalid, 1'b0);
        chk("wr_rdone", s_rvalid, 1'b0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(5))
            0:       return BASE + $urandom_range(3);
            1:       return BASE + 32'd4 + $urandom_range(3);
            2:       return BASE + 32'd8 + $urandom_range(7);
            3:       return BASE + 32'd16 * $urandom_range(100, 1);
            4:       return $urandom;
            default: return BASE + 32'd4;
        endcase
    endfunction

    initial begin
        rst = 1'b1;
        s_awvalid = 1'b0; s_awid = '0; s_awaddr = '0;
        s_wvalid  = 1'b0; s_wdata = '0; s_wstrb = '0;
        s_bready  = 1'b1;
        s_arvalid = 1'b0; s_arid = '0; s_araddr = '0;
        s_rready  = 1'b1;
        m_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        chk("rst_gpio_out", gpio_out, 32'h0);
        chk("rst_gpio_oeb", gpio_oeb, 32'hFFFF_FFFF);
        chk("rst_bvalid", s_bvalid, 1'b0);
        chk("rst_rvalid", s_rvalid, 1'b0);
        chk("rst_awready", s_awready, 1'b1);
        chk("rst_wready", s_wready, 1'b1);
        chk("rst_arready", s_arready, 1'b1);
        chk("rst_bid", s_bid, 0);
        chk("rst_rdata", s_rdata, 64'd0);

        do_write(BASE, 3'd5, 64'hDEAD_BEEF_1234_5678, 8'h0F, 0, 0);
        chk("dir_out", gpio_out, 32'h1234_5678);
        do_write(BASE + 32'd4, 3'd2, 64'h0000_00FF_0000_0000, 8'h10, 2, 0);
        chk("dir_oeb1", gpio_oeb, 32'hFFFF_FFFF);
        do_write(BASE + 32'd4, 3'd3, 64'h0, 8'h10, 0, 0);
        chk("dir_oeb2", gpio_oeb, 32'hFFFF_FF00);
        do_write(BASE + 32'd8, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        do_write(32'h8000_2000, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1, 0);
        do_write(BASE, 3'd6, 64'hAAAA_AAAA_AAAA_AAAA, 8'h00, 0, 5);
        do_read(BASE, 3'd4, 0, 1'b0);
        chk("dir_rdata", s_rdata, 64'hFFFF_FF00_1234_5678);
        write_read(BASE, 64'h0000_0000_0BAD_F00D, 8'h03, BASE);

        for (int i = 0; i < 40; i++) begin
            logic [63:0] d;
            d = {$urandom, $urandom};
            case ($urandom_range(3))
                0, 1: do_write(rand_addr(), 3'($urandom), d, 8'($urandom),
                               int'($urandom_range(4)) - 2, int'($urandom_range(3)) == 0 ? 2 : 0);
                2:    do_read(rand_addr(), 3'($urandom), int'($urandom_range(2)), 1'b0);
                default: write_read(rand_addr(), d, 8'($urandom), rand_addr());
            endcase
        end

        do_read(BASE, 3'd1, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
